yoshi_hit_detect: RTL and testbench

Consumer side of the enemy-sprite position interface. Once per video frame it samples Yoshi's position and the top-left positions published by each enemy ghost, checks hitbox overlap one ghost per clock, and on a hit decrements Yoshi's lives. It then runs an invulnerability/blink window, or latches game-over. It sits between the ghost sprite modules and the score/display control logic.

---
 rtl/yoshi_hit_detect_pkg.sv | 26 ++
 rtl/yoshi_hit_detect_if.sv | 47 ++++
 rtl/yoshi_hit_detect_box_overlap.sv | 30 +++
 rtl/yoshi_hit_detect.sv | 151 +++++++++++++++
 tb/tb_yoshi_hit_detect.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yoshi_hit_detect_pkg.sv
// yoshi_hit_detect_pkg: sprite geometry, lives default and FSM encodings
// shared by the Yoshi, ghost and hit-detect sprite logic.
package yoshi_hit_detect_pkg;

   localparam int SPRITE_W_DEF   = 16;
   localparam int LIVES_INIT_DEF = 3;
   localparam int POS_W          = 10;

   localparam logic [1:0] ST_ALIVE  = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_INVULN = 2'd2;
   localparam logic [1:0] ST_DEAD   = 2'd3;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
   } pos_t;

   // Widen a pixel coordinate so inset/edge sums cannot wrap.
   function automatic logic [POS_W:0] ext11(
      input logic [POS_W-1:0] v
   );
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/yoshi_hit_detect_if.sv
// yoshi_hit_detect_if: frame tick, sprite positions and the
// hit/lives status returned to score and display control.
interface yoshi_hit_detect_if #(
   parameter int NUM_GHOSTS = 3
);

   logic                    frame_tick;
   logic [9:0]              y_x;
   logic [9:0]              y_y;
   logic [10*NUM_GHOSTS-1:0] g_x_bus;
   logic [10*NUM_GHOSTS-1:0] g_y_bus;
   logic                    hit;
   logic [2:0]              hit_id;
   logic [2:0]              lives;
   logic                    yoshi_blink;
   logic                    invuln;
   logic                    game_over;

   modport master (
      output frame_tick,
      output y_x,
      output y_y,
      output g_x_bus,
      output g_y_bus,
      input  hit,
      input  hit_id,
      input  lives,
      input  yoshi_blink,
      input  invuln,
      input  game_over
   );

   modport slave (
      input  frame_tick,
      input  y_x,
      input  y_y,
      input  g_x_bus,
      input  g_y_bus,
      output hit,
      output hit_id,
      output lives,
      output yoshi_blink,
      output invuln,
      output game_over
   );

endinterface

// File: rtl/yoshi_hit_detect_box_overlap.sv
// box_overlap: combinational test of two inset square hitboxes
// given their top-left corners.
module box_overlap
   import yoshi_hit_detect_pkg::*;
#(
   parameter int SPRITE_W  = SPRITE_W_DEF,
   parameter int HIT_INSET = 2
) (
   input  logic [POS_W-1:0] a_x,
   input  logic [POS_W-1:0] a_y,
   input  logic [POS_W-1:0] b_x,
   input  logic [POS_W-1:0] b_y,
   output logic             overlap
);

   localparam logic [POS_W:0] A = (POS_W+1)'(HIT_INSET);
   localparam logic [POS_W:0] B = (POS_W+1)'(SPRITE_W - HIT_INSET);

   logic ovl_x;
   logic ovl_y;

   assign ovl_x = (ext11(b_x) + B > ext11(a_x) + A)
               && (ext11(a_x) + B > ext11(b_x) + A);

   assign ovl_y = (ext11(b_y) + B > ext11(a_y) + A)
               && (ext11(a_y) + B > ext11(b_y) + A);

   assign overlap = ovl_x && ovl_y;

endmodule

// File: rtl/yoshi_hit_detect.sv
// yoshi_hit_detect: per-frame Yoshi/ghost hitbox scan with lives,
// invulnerability blink window and sticky game-over.
module yoshi_hit_detect
   import yoshi_hit_detect_pkg::*;
#(
   parameter int NUM_GHOSTS    = 3,
   parameter int SPRITE_W      = SPRITE_W_DEF,
   parameter int HIT_INSET     = 2,
   parameter int LIVES_INIT    = LIVES_INIT_DEF,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_FRAMES  = 8
) (
   input logic               clk,
   input logic               reset,
   yoshi_hit_detect_if.slave bus
);

   localparam int FW = $clog2(INVULN_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam int GW = 10 * NUM_GHOSTS;

   logic [1:0]    state;
   logic [2:0]    k;
   logic [FW-1:0] fcnt;
   logic [BW-1:0] bcnt;

   pos_t          y_snap;
   logic [GW-1:0] gx_snap;
   logic [GW-1:0] gy_snap;
   pos_t          g_cur;

   logic          ovl;
   logic          last;

   logic          hit_q;
   logic [2:0]    hit_id_q;
   logic [2:0]    lives_q;
   logic          blink_q;
   logic          invuln_q;
   logic          game_over_q;

   always_comb begin
      g_cur = '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
         if (k == 3'(i)) begin
            g_cur.x = gx_snap[10*i +: 10];
            g_cur.y = gy_snap[10*i +: 10];
         end
      end
   end

   assign last = (k == 3'(NUM_GHOSTS - 1));

   box_overlap #(
      .SPRITE_W  (SPRITE_W),
      .HIT_INSET (HIT_INSET)
   ) u_ovl (
      .a_x     (y_snap.x),
      .a_y     (y_snap.y),
      .b_x     (g_cur.x),
      .b_y     (g_cur.y),
      .overlap (ovl)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_ALIVE;
         k           <= '0;
         fcnt        <= '0;
         bcnt        <= '0;
         y_snap      <= '0;
         gx_snap     <= '0;
         gy_snap     <= '0;
         hit_q       <= 1'b0;
         hit_id_q    <= '0;
         lives_q     <= 3'(LIVES_INIT);
         blink_q     <= 1'b0;
         invuln_q    <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         hit_q <= 1'b0;
         unique case (state)
            ST_ALIVE: begin
               if (bus.frame_tick) begin
                  y_snap.x <= bus.y_x;
                  y_snap.y <= bus.y_y;
                  gx_snap  <= bus.g_x_bus;
                  gy_snap  <= bus.g_y_bus;
                  k        <= '0;
                  state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (ovl) begin
                  hit_q    <= 1'b1;
                  hit_id_q <= k;
                  // Last life lost: saturate at zero and park.
                  if (lives_q <= 3'd1) begin
                     lives_q     <= '0;
                     game_over_q <= 1'b1;
                     state       <= ST_DEAD;
                  end else begin
                     lives_q  <= lives_q - 3'd1;
                     invuln_q <= 1'b1;
                     blink_q  <= 1'b1;
                     fcnt     <= FW'(INVULN_FRAMES);
                     bcnt     <= BW'(BLINK_FRAMES);
                     state    <= ST_INVULN;
                  end
               end else if (last) begin
                  state <= ST_ALIVE;
               end else begin
                  k <= k + 3'd1;
               end
            end
            ST_INVULN: begin
               if (bus.frame_tick) begin
                  if (fcnt == FW'(1)) begin
                     fcnt     <= '0;
                     invuln_q <= 1'b0;
                     blink_q  <= 1'b0;
                     state    <= ST_ALIVE;
                  end else begin
                     fcnt <= fcnt - FW'(1);
                     if (bcnt == BW'(1)) begin
                        blink_q <= ~blink_q;
                        bcnt    <= BW'(BLINK_FRAMES);
                     end else begin
                        bcnt <= bcnt - BW'(1);
                     end
                  end
               end
            end
            ST_DEAD: begin
               state <= ST_DEAD;
            end
            default: begin
               state <= ST_ALIVE;
            end
         endcase
      end
   end

   assign bus.hit         = hit_q;
   assign bus.hit_id      = hit_id_q;
   assign bus.lives       = lives_q;
   assign bus.yoshi_blink = blink_q;
   assign bus.invuln      = invuln_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_yoshi_hit_detect.sv
// tb_yoshi_hit_detect: directed and randomized frames against a
// frame-level reference model of lives, invulnerability and blink.
module tb_yoshi_hit_detect;

   localparam int NG  = 3;
   localparam int SW  = 16;
   localparam int INS = 2;
   localparam int LI  = 3;
   localparam int INV = 120;
   localparam int BF  = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   yoshi_hit_detect_if #(.NUM_GHOSTS(NG)) bus ();

   yoshi_hit_detect #(
      .NUM_GHOSTS    (NG),
      .SPRITE_W      (SW),
      .HIT_INSET     (INS),
      .LIVES_INIT    (LI),
      .INVULN_FRAMES (INV),
      .BLINK_FRAMES  (BF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   int yx, yy;
   int gx[NG];
   int gy[NG];

   int m_lives, m_left, m_since, m_hid;
   bit m_dead;

   function automatic bit ovl_ref(int ax, int ay, int bx, int by);
      int reach, dx, dy;
      reach = SW - 2 * INS;
      dx = ax - bx;
      dy = ay - by;
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      return (dx < reach) && (dy < reach);
   endfunction

   task automatic apply_pos();
      bus.y_x = 10'(yx);
      bus.y_y = 10'(yy);
      for (int i = 0; i < NG; i++) begin
         bus.g_x_bus[10*i +: 10] = 10'(gx[i]);
         bus.g_y_bus[10*i +: 10] = 10'(gy[i]);
      end
   endtask

   task automatic far_ghosts();
      gx[0] = 300; gy[0] = 300;
      gx[1] = 17;  gy[1] = 17;
      gx[2] = 400; gy[2] = 50;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_lives = LI;
      m_left = 0;
      m_since = 0;
      m_hid = 0;
      m_dead = 1'b0;
      @(negedge clk);
   endtask

   task automatic frame(input string tag, input bit scramble);
      int ek, hits, fc, ec, eh;
      bit eb;
      ek = -1;
      if (!m_dead && m_left == 0)
         for (int i = 0; i < NG; i++)
            if (ek < 0 && ovl_ref(yx, yy, gx[i], gy[i])) ek = i;
      apply_pos();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      if (scramble) begin
         bus.y_x = 10'($urandom_range(0, 1023));
         bus.y_y = 10'($urandom_range(0, 1023));
         for (int i = 0; i < NG; i++) begin
            bus.g_x_bus[10*i +: 10] = 10'($urandom_range(0, 1023));
            bus.g_y_bus[10*i +: 10] = 10'($urandom_range(0, 1023));
         end
      end
      hits = 0;
      fc = -1;
      for (int c = 1; c <= NG + 3; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.hit === 1'b1) begin
            hits++;
            if (fc < 0) fc = c;
         end
      end
      if (!m_dead) begin
         if (m_left > 0) begin
            m_left--;
            m_since++;
         end else if (ek >= 0) begin
            m_hid = ek;
            m_lives--;
            if (m_lives == 0) m_dead = 1'b1;
            else begin
               m_left = INV;
               m_since = 0;
            end
         end
      end
      ec = (ek >= 0) ? 2 + ek : -1;
      eh = (ek >= 0) ? 1 : 0;
      eb = (m_left > 0) && (((m_since / BF) % 2) == 0);
      checks++;
      if (hits != eh || fc != ec) begin
         errors++;
         $display("FAIL %s hit: pulses=%0d first=%0d, need pulses=%0d at=%0d",
                  tag, hits, fc, eh, ec);
      end
      checks++;
      if (bus.lives !== 3'(m_lives)) begin
         errors++;
         $display("FAIL %s lives: got %0d need %0d", tag, bus.lives, m_lives);
      end
      checks++;
      if (bus.hit_id !== 3'(m_hid)) begin
         errors++;
         $display("FAIL %s hit_id: got %0d need %0d", tag, bus.hit_id, m_hid);
      end
      checks++;
      if (bus.invuln !== (m_left > 0)) begin
         errors++;
         $display("FAIL %s invuln: got %b need %b", tag, bus.invuln, m_left > 0);
      end
      checks++;
      if (bus.yoshi_blink !== eb) begin
         errors++;
         $display("FAIL %s blink: got %b need %b (since=%0d)",
                  tag, bus.yoshi_blink, eb, m_since);
      end
      checks++;
      if (bus.game_over !== m_dead) begin
         errors++;
         $display("FAIL %s game_over: got %b need %b", tag, bus.game_over, m_dead);
      end
   endtask

   task automatic test_reset();
      yx = 100; yy = 100;
      far_ghosts();
      apply_pos();
      bus.frame_tick = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.lives !== 3'(LI)) begin
         errors++;
         $display("FAIL reset lives: got %0d need %0d", bus.lives, LI);
      end
      checks++;
      if ({bus.hit, bus.hit_id, bus.yoshi_blink, bus.invuln, bus.game_over}
          !== 7'b0) begin
         errors++;
         $display("FAIL reset outs: got hit=%b id=%0d blink=%b inv=%b go=%b need 0",
                  bus.hit, bus.hit_id, bus.yoshi_blink, bus.invuln, bus.game_over);
      end
      do_reset();
   endtask

   task automatic test_no_collision();
      int hits, fc;
      do_reset();
      yx = 100; yy = 100;
      far_ghosts();
      apply_pos();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      hits = 0;
      repeat (2) begin
         if (bus.hit === 1'b1) hits++;
         @(negedge clk);
      end
      if (bus.hit === 1'b1) hits++;
      checks++;
      if (hits != 0 || bus.lives !== 3'(LI) || bus.invuln !== 1'b0) begin
         errors++;
         $display("FAIL nocoll: pulses=%0d lives=%0d inv=%b need 0/%0d/0",
                  hits, bus.lives, bus.invuln, LI);
      end
      // Tick at T+4 must be accepted, proving ALIVE by then.
      gx[2] = 104; gy[2] = 96;
      apply_pos();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      hits = 0;
      fc = -1;
      for (int c = 1; c <= NG + 3; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.hit === 1'b1) begin
            hits++;
            if (fc < 0) fc = c;
         end
      end
      checks++;
      if (hits != 1 || fc != 4 || bus.hit_id !== 3'd2 || bus.lives !== 3'(LI - 1)) begin
         errors++;
         $display("FAIL alive_t4: pulses=%0d at=%0d id=%0d lives=%0d need 1/4/2/%0d",
                  hits, fc, bus.hit_id, bus.lives, LI - 1);
      end
   endtask

   task automatic test_single_hit();
      do_reset();
      yx = 100; yy = 100;
      far_ghosts();
      gx[1] = 108; gy[1] = 100;
      frame("single", 1'b0);
   endtask

   task automatic test_boundary();
      int dxs[7] = '{11, 12, 11, -11, -12, 0, 11};
      int dys[7] = '{0, 0, 12, 0, 0, 11, -11};
      for (int i = 0; i < 7; i++) begin
         do_reset();
         yx = 200; yy = 200;
         far_ghosts();
         gx[1] = 200 + dxs[i];
         gy[1] = 200 + dys[i];
         frame($sformatf("bound%0d", i), 1'b0);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      yx = 500; yy = 400;
      far_ghosts();
      gx[0] = 505; gy[0] = 395;
      gx[2] = 495; gy[2] = 406;
      frame("simul", 1'b0);
   endtask

   task automatic test_invuln_game_over();
      do_reset();
      yx = 600; yy = 300;
      far_ghosts();
      gx[1] = 603; gy[1] = 309;
      frame("inv_hit1", 1'b0);
      for (int i = 0; i < INV; i++) frame("inv_win1", 1'b0);
      frame("inv_hit2", 1'b0);
      checks++;
      if (bus.lives !== 3'd1) begin
         errors++;
         $display("FAIL inv_lives: got %0d need 1", bus.lives);
      end
      for (int i = 0; i < INV; i++) frame("inv_win2", 1'b0);
      frame("go_hit3", 1'b0);
      repeat (3) frame("go_ignored", 1'b0);
   endtask

   task automatic test_reset_mid_invuln();
      int hits;
      do_reset();
      yx = 50; yy = 60;
      far_ghosts();
      gx[2] = 45; gy[2] = 66;
      frame("rst_hit", 1'b0);
      repeat (5) frame("rst_win", 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.lives !== 3'(LI)) begin
         errors++;
         $display("FAIL rst_mid lives: got %0d need %0d", bus.lives, LI);
      end
      checks++;
      if ({bus.hit, bus.hit_id, bus.yoshi_blink, bus.invuln, bus.game_over}
          !== 7'b0) begin
         errors++;
         $display("FAIL rst_mid outs: id=%0d blink=%b inv=%b go=%b need 0",
                  bus.hit_id, bus.yoshi_blink, bus.invuln, bus.game_over);
      end
      @(negedge clk) reset = 1'b0;
      m_lives = LI; m_left = 0; m_since = 0; m_hid = 0; m_dead = 1'b0;
      hits = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.hit === 1'b1) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++;
         $display("FAIL rst_notick: pulses=%0d need 0", hits);
      end
      frame("rst_fresh", 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         do_reset();
         yx = $urandom_range(20, 1003);
         yy = $urandom_range(20, 1003);
         for (int i = 0; i < NG; i++) begin
            gx[i] = yx + $urandom_range(0, 40) - 20;
            gy[i] = yy + $urandom_range(0, 40) - 20;
         end
         frame($sformatf("rand%0d", n), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.y_x = '0;
      bus.y_y = '0;
      bus.g_x_bus = '0;
      bus.g_y_bus = '0;
      test_reset();
      test_no_collision();
      test_single_hit();
      test_boundary();
      test_simultaneous();
      test_invuln_game_over();
      test_reset_mid_invuln();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
